spoc_mem_ctrl: RTL and testbench

Unified single-port memory controller for the CPU SoC. It replaces the ideal zero-wait instruction ROM and data RAM with one shared array that has a configurable depth and access latency. It arbitrates between the instruction-fetch port and the data port, and produces the stall signal the core consumes as `is_cache_hit`. It sits between `cpu_core` and the memory array inside the SoC top.

---
 rtl/spoc_mem_ctrl_pkg.sv | 18 +
 rtl/spoc_mem_array.sv | 29 ++
 rtl/spoc_mem_ctrl.sv | 137 +++++++++++++
 tb/tb_spoc_mem_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spoc_mem_ctrl_pkg.sv
// Shared pipeline types: the common 32-bit bus plus the memory controller's
// FSM state and port-select encodings.
package pipeline_types;

  typedef logic [31:0] bus32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef enum logic {
    PORT_INST = 1'b0,
    PORT_DATA = 1'b1
  } mem_port_t;

endpackage

// File: rtl/spoc_mem_array.sv
// Unified word storage: byte-enabled synchronous write, asynchronous read.
// Contents are deliberately not reset.
module spoc_mem_array
  import pipeline_types::*;
#(
  parameter  int DEPTH_WORDS = 4096,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  bus32_t        wdata,
  input  logic [3:0]    wsel,
  output bus32_t        rdata
);

  bus32_t mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wsel[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/spoc_mem_ctrl.sv
// Single-port memory controller shared by instruction fetch and data access,
// with configurable wait states and fixed or round-robin arbitration.
module spoc_mem_ctrl
  import pipeline_types::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2,
  parameter int RR_ARB      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inst_en,
  input  bus32_t     inst_addr,
  output bus32_t     inst,
  output logic       inst_valid,
  input  logic       ram_en,
  input  logic       read_en,
  input  logic       write_en,
  input  bus32_t     addr,
  input  logic [3:0] select,
  input  bus32_t     data_i,
  output bus32_t     data_o,
  output logic       data_valid,
  output logic       data_stall
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_state_t    state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  mem_port_t     gnt, last_grant;
  logic          wr_q, oor_q;
  logic [AW-1:0] word_q;
  bus32_t        wdata_q;
  logic [3:0]    sel_q;
  bus32_t        rd_word;

  logic   inst_req, data_req, req_any, pick_data;
  logic   latch_en, access_en, mem_we;
  bus32_t req_addr;
  logic   unused_addr_bits;

  assign inst_req  = inst_en;
  assign data_req  = ram_en & (read_en | write_en);
  assign req_any   = inst_req | data_req;
  // Data wins a tie unless round-robin says data was served last.
  assign pick_data = data_req & (~inst_req | (RR_ARB == 0) | (last_grant == PORT_INST));
  assign req_addr  = pick_data ? addr : inst_addr;
  assign unused_addr_bits = ^req_addr[1:0];

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    latch_en     = 1'b0;
    access_en    = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          latch_en     = 1'b1;
          wait_cnt_nxt = CW'(LATENCY - 1);
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        if (wait_cnt == '0) begin
          access_en = 1'b1;
          state_nxt = RESP;
        end else begin
          wait_cnt_nxt = wait_cnt - CW'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: grant and control capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      gnt        <= PORT_INST;
      last_grant <= PORT_INST;
      wr_q       <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (latch_en) begin
        gnt        <= pick_data ? PORT_DATA : PORT_INST;
        last_grant <= pick_data ? PORT_DATA : PORT_INST;
        wr_q       <= pick_data & write_en;
        oor_q      <= |req_addr[31:AW+2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (latch_en) begin
      word_q  <= req_addr[AW+1:2];
      wdata_q <= data_i;
      sel_q   <= select;
    end
  end

  assign mem_we = access_en & (gnt == PORT_DATA) & wr_q & ~oor_q;

  spoc_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (word_q),
    .wdata (wdata_q),
    .wsel  (sel_q),
    .rdata (rd_word)
  );

  // p1: access edge -- register read word and one-cycle completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst       <= '0;
      data_o     <= '0;
      inst_valid <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      inst_valid <= access_en & (gnt == PORT_INST);
      data_valid <= access_en & (gnt == PORT_DATA);
      if (access_en && gnt == PORT_INST) inst <= oor_q ? '0 : rd_word;
      if (access_en && gnt == PORT_DATA && !wr_q) data_o <= oor_q ? '0 : rd_word;
    end
  end

  assign data_stall = ram_en & ~data_valid;

endmodule

// File: tb/tb_spoc_mem_ctrl.sv
// Bench for spoc_mem_ctrl: three instances (LAT2/fixed, LAT2/round-robin,
// LAT1/fixed) checked every cycle against a transaction-level model.
module tb_spoc_mem_ctrl;

  localparam int NI    = 3;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_en    [NI];
  logic [31:0] inst_addr  [NI];
  logic [31:0] inst_q     [NI];
  logic        inst_valid [NI];
  logic        ram_en     [NI];
  logic        read_en    [NI];
  logic        write_en   [NI];
  logic [31:0] addr       [NI];
  logic [3:0]  sel        [NI];
  logic [31:0] data_i     [NI];
  logic [31:0] data_o     [NI];
  logic        data_valid [NI];
  logic        data_stall [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    spoc_mem_ctrl #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     ((g == 2) ? 1 : 2),
      .RR_ARB      ((g == 1) ? 1 : 0)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .inst_en    (inst_en[g]),
      .inst_addr  (inst_addr[g]),
      .inst       (inst_q[g]),
      .inst_valid (inst_valid[g]),
      .ram_en     (ram_en[g]),
      .read_en    (read_en[g]),
      .write_en   (write_en[g]),
      .addr       (addr[g]),
      .select     (sel[g]),
      .data_i     (data_i[g]),
      .data_o     (data_o[g]),
      .data_valid (data_valid[g]),
      .data_stall (data_stall[g])
    );
  end

  int checks   = 0;
  int failures = 0;
  int n_cyc    = 0;

  // Model: memory image, outstanding transaction schedule, expected outputs.
  logic [31:0] mm [NI][DEPTH];
  bit          mk [NI][DEPTH];
  bit          m_busy [NI];
  int          m_acc  [NI];
  int          m_free [NI];
  bit          m_data [NI];
  bit          m_wr   [NI];
  bit          m_oor  [NI];
  bit          m_last [NI];
  int          m_word [NI];
  logic [31:0] m_wd   [NI];
  logic [3:0]  m_sel  [NI];
  bit          e_iv   [NI];
  bit          e_dv   [NI];
  logic [31:0] e_inst [NI];
  logic [31:0] e_do   [NI];
  bit          e_ik   [NI];
  bit          e_dk   [NI];

  function automatic int lat_of(int k);
    return (k == 2) ? 1 : 2;
  endfunction

  function automatic bit rr_of(int k);
    return (k == 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, n_cyc);
    end
  endtask

  task automatic model_step(input int k);
    bit          pi, pd, take_d;
    logic [31:0] a;
    logic [29:0] wi;
    int          w;
    if (rst) begin
      m_busy[k] = 1'b0; m_last[k] = 1'b0;
      e_iv[k] = 1'b0;   e_dv[k] = 1'b0;
      e_inst[k] = '0;   e_do[k] = '0;
      e_ik[k] = 1'b1;   e_dk[k] = 1'b1;
      return;
    end
    e_iv[k] = 1'b0;
    e_dv[k] = 1'b0;
    if (m_busy[k] && n_cyc == m_acc[k]) begin
      w = m_word[k];
      if (m_data[k]) begin
        e_dv[k] = 1'b1;
        if (m_wr[k]) begin
          if (!m_oor[k]) begin
            for (int b = 0; b < 4; b++)
              if (m_sel[k][b]) mm[k][w][8*b +: 8] = m_wd[k][8*b +: 8];
            if (m_sel[k] == 4'hF) mk[k][w] = 1'b1;
          end
        end else begin
          e_do[k] = m_oor[k] ? 32'h0 : mm[k][w];
          e_dk[k] = m_oor[k] | mk[k][w];
        end
      end else begin
        e_iv[k]   = 1'b1;
        e_inst[k] = m_oor[k] ? 32'h0 : mm[k][w];
        e_ik[k]   = m_oor[k] | mk[k][w];
      end
    end
    if (m_busy[k] && n_cyc == m_free[k]) m_busy[k] = 1'b0;
    if (!m_busy[k]) begin
      pi = inst_en[k];
      pd = ram_en[k] && (read_en[k] || write_en[k]);
      if (pi || pd) begin
        take_d    = pd && !(pi && rr_of(k) && m_last[k]);
        a         = take_d ? addr[k] : inst_addr[k];
        wi        = a[31:2];
        m_oor[k]  = (wi >= 30'(DEPTH));
        m_word[k] = m_oor[k] ? 0 : int'(wi);
        m_data[k] = take_d;
        m_wr[k]   = take_d && write_en[k];
        m_wd[k]   = data_i[k];
        m_sel[k]  = sel[k];
        m_last[k] = take_d;
        m_busy[k] = 1'b1;
        m_acc[k]  = n_cyc + lat_of(k);
        m_free[k] = n_cyc + lat_of(k) + 2;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    n_cyc++;
    for (int k = 0; k < NI; k++) begin
      model_step(k);
      chk($sformatf("u%0d inst_valid", k), 32'(inst_valid[k]), 32'(e_iv[k]));
      chk($sformatf("u%0d data_valid", k), 32'(data_valid[k]), 32'(e_dv[k]));
      chk($sformatf("u%0d data_stall", k), 32'(data_stall[k]), 32'(ram_en[k] & ~e_dv[k]));
      if (e_ik[k]) chk($sformatf("u%0d inst", k), inst_q[k], e_inst[k]);
      if (e_dk[k]) chk($sformatf("u%0d data_o", k), data_o[k], e_do[k]);
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < NI; k++) begin
      inst_en[k] = 1'b0; inst_addr[k] = '0;
      ram_en[k]  = 1'b0; read_en[k]   = 1'b0; write_en[k] = 1'b0;
      addr[k]    = '0;   sel[k]       = '0;   data_i[k]   = '0;
    end
  endtask

  task automatic data_op(input int k, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd);
    int seen;
    ram_en[k] = 1'b1; read_en[k] = !wr; write_en[k] = wr;
    addr[k] = a; data_i[k] = d; sel[k] = s;
    seen = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (data_valid[k]) begin
        seen = c;
        break;
      end
    end
    rd = data_o[k];
    if (seen < 0) begin
      checks++;
      failures++;
      $display("FAIL u%0d data_op timeout: no data_valid within 20 cycles, addr %h", k, a);
    end
    ram_en[k] = 1'b0; read_en[k] = 1'b0; write_en[k] = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] rd, rd_d, rd_i;
    int          dv_at, iv_at, nrec;
    logic [3:0]  order;
    int          vc [3];
    logic [31:0] vw [3];

    rst = 1'b1;
    idle_all();
    tick();
    tick();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d reset inst", k), inst_q[k], 32'h0);
      chk($sformatf("u%0d reset data_o", k), data_o[k], 32'h0);
    end
    rst = 1'b0;
    tick();

    // Read of word 5 with cycle-exact stall/valid timing.
    data_op(0, 1'b1, 32'd20, 32'hDEADBEEF, 4'hF, rd);
    ram_en[0] = 1'b1; read_en[0] = 1'b1; addr[0] = 32'd20;
    #1 chk("rd5 stall c0", 32'(data_stall[0]), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("rd5 stall c%0d", c), 32'(data_stall[0]), (c < 3) ? 32'd1 : 32'd0);
      chk($sformatf("rd5 valid c%0d", c), 32'(data_valid[0]), (c == 3) ? 32'd1 : 32'd0);
    end
    chk("rd5 data", data_o[0], 32'hDEADBEEF);
    ram_en[0] = 1'b0; read_en[0] = 1'b0;
    tick();
    chk("rd5 valid c4", 32'(data_valid[0]), 32'd0);

    // Byte-lane merge.
    data_op(0, 1'b1, 32'd12, 32'hAAAAAAAA, 4'hF, rd);
    data_op(0, 1'b1, 32'd12, 32'h11223344, 4'b0101, rd);
    data_op(0, 1'b0, 32'd12, 32'h0, 4'h0, rd);
    chk("merge read", rd, 32'hAA22AA44);

    // Fixed priority contention: data first, inst LATENCY+2 later.
    data_op(0, 1'b1, 32'd4, 32'h00001111, 4'hF, rd);
    data_op(0, 1'b1, 32'd8, 32'h22220000, 4'hF, rd);
    inst_en[0] = 1'b1; inst_addr[0] = 32'd4;
    ram_en[0] = 1'b1; read_en[0] = 1'b1; addr[0] = 32'd8;
    dv_at = -1; iv_at = -1; rd_d = '0; rd_i = '0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (data_valid[0] && dv_at < 0) begin
        dv_at = c; rd_d = data_o[0]; ram_en[0] = 1'b0; read_en[0] = 1'b0;
      end
      if (inst_valid[0] && iv_at < 0) begin
        iv_at = c; rd_i = inst_q[0]; inst_en[0] = 1'b0;
      end
      if (dv_at >= 0 && iv_at >= 0) break;
    end
    chk("fixed arb data cycle", 32'(dv_at), 32'd3);
    chk("fixed arb inst cycle", 32'(iv_at), 32'd7);
    chk("fixed arb data word", rd_d, 32'h22220000);
    chk("fixed arb inst word", rd_i, 32'h00001111);
    idle_all();
    tick();

    // Round-robin: preload leaves last grant = data, so inst goes first.
    data_op(1, 1'b1, 32'd4, 32'h0000AAAA, 4'hF, rd);
    data_op(1, 1'b1, 32'd8, 32'h0000BBBB, 4'hF, rd);
    inst_en[1] = 1'b1; inst_addr[1] = 32'd4;
    ram_en[1] = 1'b1; read_en[1] = 1'b1; addr[1] = 32'd8;
    nrec = 0; order = 4'hF;
    for (int c = 1; c <= 60 && nrec < 4; c++) begin
      tick();
      if (inst_valid[1]) begin order[3 - nrec] = 1'b0; nrec++; end
      if (data_valid[1] && nrec < 4) begin order[3 - nrec] = 1'b1; nrec++; end
    end
    idle_all();
    chk("rr grant order", 32'(order), 32'h5);
    chk("rr inst word", inst_q[1], 32'h0000AAAA);
    tick();

    // Out of range: read returns 0, write dropped (no wrap onto word 0).
    data_op(0, 1'b1, 32'd0, 32'h0BADF00D, 4'hF, rd);
    data_op(0, 1'b0, 32'd64, 32'h0, 4'h0, rd);
    chk("oor read", rd, 32'h0);
    data_op(0, 1'b1, 32'd64, 32'hFFFFFFFF, 4'hF, rd);
    data_op(0, 1'b0, 32'd0, 32'h0, 4'h0, rd);
    chk("oor write dropped", rd, 32'h0BADF00D);

    // Reset during BUSY of a write: aborted, no valid, outputs cleared.
    data_op(0, 1'b1, 32'd36, 32'h55AA55AA, 4'hF, rd);
    data_op(0, 1'b0, 32'd20, 32'h0, 4'h0, rd);
    ram_en[0] = 1'b1; write_en[0] = 1'b1; addr[0] = 32'd36;
    data_i[0] = 32'h12345678; sel[0] = 4'hF;
    tick();
    rst = 1'b1;
    idle_all();
    #1;
    chk("rst mid data_o", data_o[0], 32'h0);
    chk("rst mid inst", inst_q[0], 32'h0);
    chk("rst mid data_valid", 32'(data_valid[0]), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 1) rst = 1'b0;
      chk($sformatf("rst no valid c%0d", c), 32'(data_valid[0]), 32'd0);
    end
    data_op(0, 1'b0, 32'd36, 32'h0, 4'h0, rd);
    chk("rst write aborted", rd, 32'h55AA55AA);

    // LATENCY=1 continuous fetch: one completion every 3 cycles.
    data_op(2, 1'b1, 32'd0, 32'hA0000000, 4'hF, rd);
    data_op(2, 1'b1, 32'd4, 32'hA1111111, 4'hF, rd);
    data_op(2, 1'b1, 32'd8, 32'hA2222222, 4'hF, rd);
    for (int i = 0; i < 3; i++) begin vc[i] = -100; vw[i] = '0; end
    inst_en[2] = 1'b1; inst_addr[2] = 32'd0;
    nrec = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (inst_valid[2]) begin
        vc[nrec] = c; vw[nrec] = inst_q[2]; nrec++;
        if (nrec == 3) begin
          inst_en[2] = 1'b0;
          break;
        end
        inst_addr[2] = 32'(nrec * 4);
      end
    end
    chk("lat1 first valid", 32'(vc[0]), 32'd2);
    chk("lat1 gap 1", 32'(vc[1] - vc[0]), 32'd3);
    chk("lat1 gap 2", 32'(vc[2] - vc[1]), 32'd3);
    chk("lat1 word 0", vw[0], 32'hA0000000);
    chk("lat1 word 1", vw[1], 32'hA1111111);
    chk("lat1 word 2", vw[2], 32'hA2222222);
    idle_all();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
